// File: rtl/bcd_number_entry.sv
// Push-button entry of a two-digit BCD number (01..MAX_VALUE): sync, debounce, edge detect, edit FSM.
// Build option: define DEBOUNCE_EN to instantiate the debouncers; otherwise they are bypassed.
//
// state | meaning
// IDLE  | waiting for start, display off, number held
// EDIT  | digits being edited, display on
// SHOW  | accepted number displayed, only start is honoured
module bcd_number_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_VALUE       = 75
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_start,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_ok,
  output logic [7:0] number,
  output logic       display_en,
  output logic       edit_tens,
  output logic       number_valid,
  output logic       number_error
);

  typedef enum logic [1:0] {IDLE, EDIT, SHOW} state_t;

  localparam logic [6:0] MAX_VAL = 7'(MAX_VALUE);

  // bit order: 0 start, 1 inc, 2 next, 3 ok
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb_lvl;
  logic [3:0] deb_prev_q;
  logic [3:0] press;

  assign btn_raw = {btn_ok, btn_next, btn_inc, btn_start};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_prev_q <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_lvl;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  // counter only runs while the synchronised level disagrees with the accepted level
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_lvl = deb_q;
`else
  assign deb_lvl = sync2_q;
`endif

  assign press = deb_lvl & ~deb_prev_q;

  state_t     state_q, state_d;
  logic [7:0] number_q, number_d;
  logic       edit_tens_q, edit_tens_d;
  logic       display_en_q, display_en_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic [6:0] value;
  logic [3:0] digit, digit_inc;

  always_comb begin
    value       = 7'(number_q[7:4]) * 7'd10 + 7'(number_q[3:0]);
    digit       = edit_tens_q ? number_q[7:4] : number_q[3:0];
    digit_inc   = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    state_d     = state_q;
    number_d    = number_q;
    edit_tens_d = edit_tens_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      IDLE, SHOW: begin
        if (press[0]) begin
          state_d     = EDIT;
          number_d    = 8'h00;
          edit_tens_d = 1'b0;
        end
      end
      EDIT: begin
        if (press[0]) begin
          number_d    = 8'h00;
          edit_tens_d = 1'b0;
        end else if (press[3]) begin
          if (value != 7'd0 && value <= MAX_VAL) begin
            valid_d     = 1'b1;
            state_d     = SHOW;
            edit_tens_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end else if (press[2]) begin
          edit_tens_d = ~edit_tens_q;
        end else if (press[1]) begin
          if (edit_tens_q) number_d[7:4] = digit_inc;
          else             number_d[3:0] = digit_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    display_en_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      number_q     <= 8'h00;
      edit_tens_q  <= 1'b0;
      display_en_q <= 1'b0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      number_q     <= number_d;
      edit_tens_q  <= edit_tens_d;
      display_en_q <= display_en_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  assign number       = number_q;
  assign display_en   = display_en_q;
  assign edit_tens    = edit_tens_q;
  assign number_valid = valid_q;
  assign number_error = error_q;

endmodule

// File: tb/tb_bcd_number_entry.sv
// Self-checking bench for bcd_number_entry: vector table, hand-written timing/reset cases,
// and random button traffic against an arithmetic reference model.
module tb_bcd_number_entry;

`ifdef DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 2 + DB;
  localparam int HOLD = LAT + 2;

  localparam logic [3:0] START = 4'b0001;
  localparam logic [3:0] INC   = 4'b0010;
  localparam logic [3:0] NEXT  = 4'b0100;
  localparam logic [3:0] OK    = 4'b1000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       btn_start = 1'b0, btn_inc = 1'b0, btn_next = 1'b0, btn_ok = 1'b0;
  logic [7:0] number;
  logic       display_en, edit_tens, number_valid, number_error;

  bcd_number_entry #(.DEBOUNCE_CYCLES(4), .MAX_VALUE(75)) dut (
    .clk(clk), .rstn(rstn),
    .btn_start(btn_start), .btn_inc(btn_inc), .btn_next(btn_next), .btn_ok(btn_ok),
    .number(number), .display_en(display_en), .edit_tens(edit_tens),
    .number_valid(number_valid), .number_error(number_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt = 0, ecnt = 0, bothcnt = 0;

  always @(negedge clk) begin
    if (number_valid) vcnt++;
    if (number_error) ecnt++;
    if (number_valid && number_error) bothcnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_btn(input logic [3:0] m);
    btn_start = m[0];
    btn_inc   = m[1];
    btn_next  = m[2];
    btn_ok    = m[3];
  endtask

  task automatic tap(input logic [3:0] m);
    @(posedge clk); #1;
    set_btn(m);
    repeat (HOLD) @(posedge clk);
    #1 set_btn(4'b0000);
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic tap_check(input logic [3:0] m, input logic [7:0] en, input bit ed,
                           input bit et, input bit ev, input bit ee, input string name);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    tap(m);
    check({name, ".number"},     number,     en);
    check({name, ".display_en"}, display_en, ed);
    check({name, ".edit_tens"},  edit_tens,  et);
    check({name, ".valid_pulses"}, vcnt - v0, ev);
    check({name, ".error_pulses"}, ecnt - e0, ee);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [7:0] num;
    bit         disp, tens, v, e;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [3:0] m, input logic [7:0] n, input bit d,
                              input bit t, input bit v, input bit e);
    vec_t r;
    r.mask = m; r.num = n; r.disp = d; r.tens = t; r.v = v; r.e = e;
    tbl.push_back(r);
  endfunction

  // reference model: mode 0 idle, 1 editing, 2 showing
  int m_mode = 0, m_t = 0, m_u = 0, m_et = 0;

  task automatic model_step(input logic [3:0] m, output bit ev, output bit ee);
    int val;
    ev = 0;
    ee = 0;
    if (m_mode != 1) begin
      if (m[0]) begin m_mode = 1; m_t = 0; m_u = 0; m_et = 0; end
    end else if (m[0]) begin
      m_t = 0; m_u = 0; m_et = 0;
    end else if (m[3]) begin
      val = m_t * 10 + m_u;
      if (val >= 1 && val <= 75) begin ev = 1; m_mode = 2; m_et = 0; end
      else ee = 1;
    end else if (m[2]) begin
      m_et = 1 - m_et;
    end else if (m[1]) begin
      if (m_et != 0) m_t = (m_t + 1) % 10;
      else           m_u = (m_u + 1) % 10;
    end
  endtask

  initial begin
    logic [3:0] m;
    logic [7:0] en;
    bit ev, ee;

    // reset and quiet period
    set_btn(4'b0000);
    #23 rstn = 1'b1;
    begin
      int v0, e0;
      v0 = vcnt; e0 = ecnt;
      repeat (20) @(posedge clk);
      #1;
      check("reset.number", number, 8'h00);
      check("reset.display_en", display_en, 0);
      check("reset.edit_tens", edit_tens, 0);
      check("reset.no_pulses", (vcnt - v0) + (ecnt - e0), 0);
    end

    // vector table
    add(INC,   8'h00, 0, 0, 0, 0);
    add(START, 8'h00, 1, 0, 0, 0);
    add(INC,   8'h01, 1, 0, 0, 0);
    add(INC,   8'h02, 1, 0, 0, 0);
    add(INC,   8'h03, 1, 0, 0, 0);
    add(NEXT,  8'h03, 1, 1, 0, 0);
    add(INC,   8'h13, 1, 1, 0, 0);
    add(INC,   8'h23, 1, 1, 0, 0);
    add(OK,    8'h23, 1, 0, 1, 0);
    add(INC,   8'h23, 1, 0, 0, 0);
    add(NEXT,  8'h23, 1, 0, 0, 0);
    add(OK,    8'h23, 1, 0, 0, 0);
    add(START, 8'h00, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(INC, {4'h0, 4'(i % 10)}, 1, 0, 0, 0);
    add(NEXT,  8'h00, 1, 1, 0, 0);
    for (int i = 1; i <= 11; i++) add(INC, {4'(i % 10), 4'h0}, 1, 1, 0, 0);
    for (int i = 2; i <= 8; i++)  add(INC, {4'(i), 4'h0}, 1, 1, 0, 0);
    add(OK,    8'h80, 1, 1, 0, 1);
    add(START, 8'h00, 1, 0, 0, 0);
    add(OK,    8'h00, 1, 0, 0, 1);
    for (int i = 1; i <= 5; i++)  add(INC, {4'h0, 4'(i)}, 1, 0, 0, 0);
    add(NEXT,  8'h05, 1, 1, 0, 0);
    for (int i = 1; i <= 7; i++)  add(INC, {4'(i), 4'h5}, 1, 1, 0, 0);
    add(OK,    8'h75, 1, 0, 1, 0);
    add(START, 8'h00, 1, 0, 0, 0);
    add(INC,   8'h01, 1, 0, 0, 0);
    add(OK | INC, 8'h01, 1, 0, 1, 0);
    add(START | OK | NEXT | INC, 8'h00, 1, 0, 0, 0);
    add(NEXT | INC, 8'h00, 1, 1, 0, 0);
    add(OK | NEXT | INC, 8'h00, 1, 1, 0, 1);
    foreach (tbl[i])
      tap_check(tbl[i].mask, tbl[i].num, tbl[i].disp, tbl[i].tens, tbl[i].v, tbl[i].e,
                $sformatf("vec%0d", i));

    // exact press latency: 6-cycle raw press
    tap_check(START, 8'h00, 1, 0, 0, 0, "lat.start");
    @(posedge clk); #1;
    btn_inc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 6) btn_inc = 1'b0;
      if (k == LAT)     check("lat.before_edge", number, 8'h00);
      if (k == LAT + 1) check("lat.at_edge", number, 8'h01);
    end
    repeat (2 * HOLD) @(posedge clk);
    #1 check("lat.single_inc", number, 8'h01);

`ifdef DEBOUNCE_EN
    // 3-cycle glitch is filtered
    @(posedge clk); #1;
    btn_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_inc = 1'b0;
    repeat (2 * HOLD) @(posedge clk);
    #1 check("glitch.number", number, 8'h01);
`endif

    // reset mid-entry aborts asynchronously
    tap_check(START, 8'h00, 1, 0, 0, 0, "rst.start");
    for (int i = 1; i <= 4; i++) tap_check(INC, {4'h0, 4'(i)}, 1, 0, 0, 0, "rst.inc");
    tap_check(NEXT, 8'h04, 1, 1, 0, 0, "rst.next");
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("rst.async_number", number, 8'h00);
    check("rst.async_display_en", display_en, 0);
    check("rst.async_edit_tens", edit_tens, 0);
    #20 rstn = 1'b1;
    tap_check(INC, 8'h00, 0, 0, 0, 0, "rst.idle_ignores_inc");

    // random traffic against the model (DUT now in IDLE)
    m_mode = 0; m_t = 0; m_u = 0; m_et = 0;
    for (int n = 0; n < 150; n++) begin
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) m[0] = 1'b0;
      if ($urandom_range(0, 2) != 0) m[3] = 1'b0;
      model_step(m, ev, ee);
      en = {4'(m_t), 4'(m_u)};
      tap_check(m, en, m_mode != 0, m_et != 0, ev, ee, $sformatf("rnd%0d", n));
    end

    check("valid_error_overlap", bothcnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
